// File: rtl/booth_mul_iter.sv
// booth_mul_iter: iterative radix-4 Booth multiplier with a valid/ready handshake.
// It accumulates PP_PER_CYCLE Booth partial products per clock into a double-width
// accumulator. It handles signed, unsigned and mixed-sign operands.
// Optional feature macro: BOOTH_MUL_FLUSH_EN adds a 'flush' input. That input aborts
// the operation in flight and returns the unit to IDLE.
module booth_mul_iter #(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BOOTH_MUL_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 x_signed,
    input  logic                 y_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    // Product width, Booth group count and the number of compute cycles.
    localparam int PW     = 2 * WIDTH;
    localparam int NGROUP = (WIDTH + 2) / 2;
    localparam int NCYC   = (NGROUP + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    localparam int STEP   = 2 * PP_PER_CYCLE;

    // The multiplier window is padded to a whole number of steps, plus the implicit y[-1].
    // The pad bits replicate the extension bit.
    // Booth triples past group N-1 are therefore 000 or 111 and contribute nothing.
    localparam int YW     = STEP * NCYC + 1;
    localparam int CW     = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

    // Reject configurations the datapath is not built for.
    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0) ||
            !((PP_PER_CYCLE == 1) || (PP_PER_CYCLE == 2) || (PP_PER_CYCLE == 4))) begin : gBadParams
            $error("booth_mul_iter: illegal WIDTH or PP_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [YW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   result_q, result_d;
    logic [PW-1:0]   ppSum;
    logic [PW-1:0]   xExt;
    logic [YW-2:0]   yExt;
    logic            flushHit;

`ifdef BOOTH_MUL_FLUSH_EN
    assign flushHit = flush;
`else
    assign flushHit = 1'b0;
`endif

    // Map one Booth triple to its group term. The caller applies the group's 2i shift.
    function automatic logic [PW-1:0] boothTerm(input logic [2:0] trip, input logic [PW-1:0] m);
        logic [PW-1:0] t;
        case (trip)
            3'b001, 3'b010: t = m;
            3'b011:         t = m << 1;
            3'b100:         t = -(m << 1);
            3'b101, 3'b110: t = -m;
            default:        t = '0;
        endcase
        return t;
    endfunction

    // Operand extension on acceptance.
    assign xExt = x_signed ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    assign yExt = {{(YW - 1 - WIDTH){y_signed & y[WIDTH-1]}}, y};

    // Sum of this cycle's group terms.
    // The multiplicand register is already pre-shifted to the current window position.
    always_comb begin
        ppSum = '0;
        for (int j = 0; j < PP_PER_CYCLE; j++) begin
            ppSum = ppSum + (boothTerm(mplier_q[2*j +: 3], mcand_q) << (2 * j));
        end
    end

    // Next-state, datapath update and handshake decisions. Flush overrides everything else.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = xExt;
                    mplier_d = {yExt, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_q + ppSum;
                mcand_d  = mcand_q << STEP;
                mplier_d = {{STEP{mplier_q[YW-1]}}, mplier_q[YW-1:STEP]};
                if (cnt_q == LAST_CNT) begin
                    result_d = acc_q + ppSum;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flushHit) begin
            state_d  = IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter at its default configuration.
// Checks come from a table of known products, hand-written handshake and reset sequences,
// and random operands compared against a plain-arithmetic product model.
// The flush sequence is built only when BOOTH_MUL_FLUSH_EN is defined.
module tb_booth_mul_iter;

    localparam int W       = 32;
    localparam int PP      = 2;
    localparam int EXP_LAT = ((W + 2) / 2 + PP - 1) / PP;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    x = '0;
    logic [W-1:0]    y = '0;
    logic            x_signed = 1'b0;
    logic            y_signed = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  result;
`ifdef BOOTH_MUL_FLUSH_EN
    logic            flush = 1'b0;
`endif

    int assertCount = 0;
    int failCount   = 0;

    booth_mul_iter #(.WIDTH(W), .PP_PER_CYCLE(PP)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BOOTH_MUL_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .x_signed  (x_signed),
        .y_signed  (y_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   vx;
        logic [W-1:0]   vy;
        logic           vxs;
        logic           vys;
        logic [2*W-1:0] expected;
    } vec_t;

    vec_t vecs[7];

    // Reference: extend both operands to 2W bits and multiply modulo 2^(2W).
    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic as, input logic bs);
        logic [2*W-1:0] ae, be;
        ae = as ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        be = bs ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ae * be;
    endfunction

    task automatic checkOutput(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present operands and wait for the accept edge. Returns at the following negedge.
    task automatic acceptOp(input logic [W-1:0] ax, input logic [W-1:0] ay,
                            input logic axs, input logic ays);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready before accept", {63'b0, in_ready}, 64'd1);
        x = ax; y = ay; x_signed = axs; y_signed = ays;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid. The result is -1 on timeout.
    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] ax, input logic [W-1:0] ay,
                                 input logic axs, input logic ays, output int lat);
        acceptOp(ax, ay, axs, ays);
        waitValid(lat);
    endtask

    // Sample the result and complete the output handshake.
    task automatic collect(output logic [2*W-1:0] res);
        res = result;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic runAndCheck(input string name, input logic [W-1:0] ax, input logic [W-1:0] ay,
                               input logic axs, input logic ays, input logic [2*W-1:0] exp);
        int lat;
        logic [2*W-1:0] res;
        applyStimulus(ax, ay, axs, ays, lat);
        checkOutput({name, " latency"}, 64'(lat), 64'(EXP_LAT));
        if (lat < 0) res = '0;
        else collect(res);
        checkOutput(name, res, exp);
    endtask

    initial begin
        logic [2*W-1:0] held, res;
        logic           sawValid;
        int             lat;
        logic [W-1:0]   rx, ry;
        logic           rxs, rys;

        vecs[0] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFEB};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF_00000001};
        vecs[4] = '{32'h00000005, 32'h00000006, 1'b0, 1'b0, 64'h00000000_0000001E};
        vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 64'hC0000000_80000000};
        vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF_80000000};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("reset in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("reset result", result, 64'd0);

        // Known-product table
        for (int i = 0; i < 7; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].vx, vecs[i].vy, vecs[i].vxs, vecs[i].vys,
                        vecs[i].expected);
        end

        // Backpressure: result and handshake signals hold while out_ready is low
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, lat);
        checkOutput("bp latency", 64'(lat), 64'(EXP_LAT));
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp result stable", result, held);
            checkOutput("bp in_ready low", {63'b0, in_ready}, 64'd0);
            checkOutput("bp out_valid high", {63'b0, out_valid}, 64'd1);
        end
        collect(res);
        checkOutput("bp result", res, refProduct(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1));
        checkOutput("bp in_ready after handshake", {63'b0, in_ready}, 64'd1);
        checkOutput("bp out_valid after handshake", {63'b0, out_valid}, 64'd0);
        checkOutput("bp result held in IDLE", result, held);

        // Operands presented during BUSY/DONE are ignored and not accepted
        acceptOp(32'd3, 32'd4, 1'b0, 1'b0);
        in_valid = 1'b1; x = 32'hDEADBEEF; y = 32'h0BADF00D;
        waitValid(lat);
        checkOutput("busy-hold latency", 64'(lat), 64'(EXP_LAT));
        checkOutput("done in_ready low", {63'b0, in_ready}, 64'd0);
        collect(res);
        checkOutput("busy-hold result", res, 64'd12);
        checkOutput("no accept in handshake cycle", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b0;

        // Reset in the fourth BUSY cycle
        acceptOp(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid-reset out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("mid-reset in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("mid-reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("no out_valid after reset", {63'b0, sawValid}, 64'd0);
        runAndCheck("post-reset 5x6", 32'd5, 32'd6, 1'b0, 1'b0, 64'd30);

`ifdef BOOTH_MUL_FLUSH_EN
        // A flush in BUSY drops the operation and leaves result untouched
        held = result;
        acceptOp(32'd77, 32'd99, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush in_ready", {63'b0, in_ready}, 64'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("no out_valid after flush", {63'b0, sawValid}, 64'd0);
        checkOutput("flush keeps result", result, held);
        runAndCheck("post-flush", 32'hFFFFFFF9, 32'd11, 1'b1, 1'b0, refProduct(32'hFFFFFFF9, 32'd11, 1'b1, 1'b0));
`endif

        // Random operands across all sign modes, with some corner values mixed in
        for (int i = 0; i < 200; i++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: rx = 32'h80000000;
                1: ry = 32'hFFFFFFFF;
                2: rx = 32'h0;
                3: ry = 32'h7FFFFFFF;
                default: ;
            endcase
            rxs = 1'($urandom_range(0, 1));
            rys = 1'($urandom_range(0, 1));
            runAndCheck($sformatf("rand%0d", i), rx, ry, rxs, rys, refProduct(rx, ry, rxs, rys));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $fatal(1, "[TB] timeout");
    end

endmodule
